// File: rtl/label_fusion.sv
// Fuses per-channel associative-memory labels by majority vote over a
// sliding history of confident samples (arousal and valence channels).
module label_fusion #(
   parameter int LABEL_WIDTH    = 1,
   parameter int DISTANCE_WIDTH = 10,
   parameter int WINDOW         = 5,
   parameter int DIST_THRESHOLD = 400
) (
   input  logic                      Clk_CI,
   input  logic                      Reset_RI,
   input  logic                      ValidIn_SI,
   output logic                      ReadyOut_SO,
   input  logic [LABEL_WIDTH-1:0]    LabelIn_A_DI,
   input  logic [LABEL_WIDTH-1:0]    LabelIn_V_DI,
   input  logic [DISTANCE_WIDTH-1:0] DistanceIn_A_DI,
   input  logic [DISTANCE_WIDTH-1:0] DistanceIn_V_DI,
   input  logic                      Flush_SI,
   output logic                      ValidOut_SO,
   input  logic                      ReadyIn_SI,
   output logic [LABEL_WIDTH-1:0]    LabelOut_A_DO,
   output logic [LABEL_WIDTH-1:0]    LabelOut_V_DO,
   output logic                      Confident_A_SO,
   output logic                      Confident_V_SO
);

   localparam int CW = $clog2(WINDOW + 1);
   localparam logic [31:0] THR = 32'(DIST_THRESHOLD);

   typedef enum logic [1:0] {
      IDLE, UPDATE, VOTE, OUTPUT_STABLE
   } state_t;

   state_t state;

   logic [LABEL_WIDTH-1:0]    lab_a, lab_v;
   logic [DISTANCE_WIDTH-1:0] dist_a, dist_v;
   logic [WINDOW-1:0][LABEL_WIDTH-1:0] hist_a, hist_v;
   logic [CW-1:0] fill_a, fill_v;
   logic [CW-1:0] ones_a, ones_v;
   logic [CW:0]   two_a, two_v, fext_a, fext_v;
   logic          acc_a, acc_v;

   assign acc_a = 32'(dist_a) <= THR;
   assign acc_v = 32'(dist_v) <= THR;

   assign ReadyOut_SO = (state == IDLE) && !Flush_SI;

   // Entry 0 is the newest; only the lowest fill entries are valid.
   always_comb begin
      ones_a = '0;
      ones_v = '0;
      for (int i = 0; i < WINDOW; i++) begin
         if (CW'(i) < fill_a && hist_a[i] == LABEL_WIDTH'(1))
            ones_a = ones_a + CW'(1);
         if (CW'(i) < fill_v && hist_v[i] == LABEL_WIDTH'(1))
            ones_v = ones_v + CW'(1);
      end
   end

   assign two_a  = {ones_a, 1'b0};
   assign two_v  = {ones_v, 1'b0};
   assign fext_a = {1'b0, fill_a};
   assign fext_v = {1'b0, fill_v};

   always_ff @(posedge Clk_CI or posedge Reset_RI) begin
      if (Reset_RI) begin
         state          <= IDLE;
         lab_a          <= '0;
         lab_v          <= '0;
         dist_a         <= '0;
         dist_v         <= '0;
         hist_a         <= '0;
         hist_v         <= '0;
         fill_a         <= '0;
         fill_v         <= '0;
         LabelOut_A_DO  <= '0;
         LabelOut_V_DO  <= '0;
         Confident_A_SO <= 1'b0;
         Confident_V_SO <= 1'b0;
         ValidOut_SO    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (Flush_SI) begin
                  hist_a <= '0;
                  hist_v <= '0;
                  fill_a <= '0;
                  fill_v <= '0;
               end else if (ValidIn_SI) begin
                  lab_a  <= LabelIn_A_DI;
                  lab_v  <= LabelIn_V_DI;
                  dist_a <= DistanceIn_A_DI;
                  dist_v <= DistanceIn_V_DI;
                  state  <= UPDATE;
               end
            end
            UPDATE: begin
               if (acc_a) begin
                  hist_a <= {hist_a[WINDOW-2:0], lab_a};
                  if (fill_a != CW'(WINDOW))
                     fill_a <= fill_a + CW'(1);
               end
               if (acc_v) begin
                  hist_v <= {hist_v[WINDOW-2:0], lab_v};
                  if (fill_v != CW'(WINDOW))
                     fill_v <= fill_v + CW'(1);
               end
               state <= VOTE;
            end
            VOTE: begin
               // A tie (including an empty history) keeps the old label.
               if (two_a > fext_a)
                  LabelOut_A_DO <= LABEL_WIDTH'(1);
               else if (two_a < fext_a)
                  LabelOut_A_DO <= '0;
               if (two_v > fext_v)
                  LabelOut_V_DO <= LABEL_WIDTH'(1);
               else if (two_v < fext_v)
                  LabelOut_V_DO <= '0;
               Confident_A_SO <= acc_a;
               Confident_V_SO <= acc_v;
               ValidOut_SO    <= 1'b1;
               state          <= OUTPUT_STABLE;
            end
            OUTPUT_STABLE: begin
               if (ReadyIn_SI) begin
                  ValidOut_SO <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_label_fusion.sv
// Randomised self-checking bench for label_fusion with a queue-based
// majority-vote reference model.
module tb_label_fusion;

   localparam int LW  = 1;
   localparam int DW  = 10;
   localparam int WIN = 5;
   localparam int THR = 400;

   logic          clk = 1'b0;
   logic          rst;
   logic          valid_in;
   logic          ready_out;
   logic [LW-1:0] lab_in_a, lab_in_v;
   logic [DW-1:0] dist_a, dist_v;
   logic          flush;
   logic          valid_out;
   logic          ready_in;
   logic [LW-1:0] lab_out_a, lab_out_v;
   logic          conf_a, conf_v;

   int tests = 0;
   int fails = 0;

   bit qa[$];
   bit qv[$];
   bit ref_lab[2];
   bit ref_conf[2];

   always #5 clk = ~clk;

   label_fusion dut (
      .Clk_CI          (clk),
      .Reset_RI        (rst),
      .ValidIn_SI      (valid_in),
      .ReadyOut_SO     (ready_out),
      .LabelIn_A_DI    (lab_in_a),
      .LabelIn_V_DI    (lab_in_v),
      .DistanceIn_A_DI (dist_a),
      .DistanceIn_V_DI (dist_v),
      .Flush_SI        (flush),
      .ValidOut_SO     (valid_out),
      .ReadyIn_SI      (ready_in),
      .LabelOut_A_DO   (lab_out_a),
      .LabelOut_V_DO   (lab_out_v),
      .Confident_A_SO  (conf_a),
      .Confident_V_SO  (conf_v)
   );

   function automatic void model_clear();
      qa.delete();
      qv.delete();
   endfunction

   function automatic void model_step(int ch, bit lab, int d);
      bit acc = (d <= THR);
      int ones = 0;
      int n;
      if (ch == 0) begin
         if (acc) begin
            qa.push_front(lab);
            if (qa.size() > WIN) void'(qa.pop_back());
         end
         n = qa.size();
         foreach (qa[i]) ones += int'(qa[i]);
      end else begin
         if (acc) begin
            qv.push_front(lab);
            if (qv.size() > WIN) void'(qv.pop_back());
         end
         n = qv.size();
         foreach (qv[i]) ones += int'(qv[i]);
      end
      ref_conf[ch] = acc;
      if (2 * ones > n) ref_lab[ch] = 1'b1;
      else if (2 * ones < n) ref_lab[ch] = 1'b0;
   endfunction

   function automatic logic [4:0] act_vec();
      return {valid_out, lab_out_a[0], lab_out_v[0], conf_a, conf_v};
   endfunction

   function automatic logic [4:0] exp_vec();
      return {1'b1, ref_lab[0], ref_lab[1], ref_conf[0], ref_conf[1]};
   endfunction

   task automatic send(bit la, int da, bit lv, int dv);
      @(negedge clk);
      valid_in = 1'b1;
      lab_in_a = la;
      lab_in_v = lv;
      dist_a   = DW'(da);
      dist_v   = DW'(dv);
      ready_in = 1'b0;
      @(posedge clk);
      @(negedge clk);
      valid_in = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      model_step(0, la, da);
      model_step(1, lv, dv);
   endtask

   task automatic release_out();
      ready_in = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ready_in = 1'b0;
   endtask

   task automatic do_flush();
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
      model_clear();
   endtask

   task automatic test_reset();
      rst = 1'b1; valid_in = 0; flush = 0; ready_in = 0;
      lab_in_a = 0; lab_in_v = 0; dist_a = 0; dist_v = 0;
      repeat (3) @(negedge clk);
      tests++;
      if ({act_vec(), ready_out} !== 6'b000001) begin
         fails++;
         $display("FAIL reset: got %b want 000001", {act_vec(), ready_out});
      end
      rst = 1'b0;
      model_clear();
      ref_lab = '{0, 0};
      ref_conf = '{0, 0};
   endtask

   task automatic test_basic();
      @(negedge clk);
      valid_in = 1; lab_in_a = 1; dist_a = 100; lab_in_v = 0; dist_v = 50;
      @(posedge clk);
      @(negedge clk);
      valid_in = 0;
      tests++;
      if (valid_out !== 1'b0) begin
         fails++;
         $display("FAIL latency_e1: got %b want 0", valid_out);
      end
      @(posedge clk);
      @(negedge clk);
      tests++;
      if (valid_out !== 1'b0) begin
         fails++;
         $display("FAIL latency_e2: got %b want 0", valid_out);
      end
      @(posedge clk);
      @(negedge clk);
      model_step(0, 1, 100);
      model_step(1, 0, 50);
      tests++;
      if ({act_vec(), ready_out} !== 6'b110110) begin
         fails++;
         $display("FAIL basic: got %b want 110110", {act_vec(), ready_out});
      end
      release_out();
   endtask

   task automatic test_majority();
      bit seq[6] = '{1, 0, 0, 1, 0, 0};
      bit want[6] = '{1, 1, 0, 0, 0, 0};
      do_flush();
      for (int i = 0; i < 6; i++) begin
         send(seq[i], 100, 1, 500);
         tests++;
         if (lab_out_a[0] !== want[i] || act_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL majority[%0d]: got %b want %b (A=%b)",
                     i, act_vec(), exp_vec(), want[i]);
         end
         release_out();
      end
   endtask

   task automatic test_threshold();
      do_flush();
      send(1, 401, 1, 50);
      tests++;
      if (lab_out_a[0] !== 1'b0 || conf_a !== 1'b0 ||
          lab_out_v[0] !== 1'b1 || conf_v !== 1'b1 ||
          act_vec() !== exp_vec()) begin
         fails++;
         $display("FAIL reject_401: got %b want %b", act_vec(), exp_vec());
      end
      release_out();
      send(1, 400, 0, 0);
      tests++;
      if (lab_out_a[0] !== 1'b1 || conf_a !== 1'b1 ||
          act_vec() !== exp_vec()) begin
         fails++;
         $display("FAIL accept_400: got %b want %b", act_vec(), exp_vec());
      end
      release_out();
   endtask

   task automatic test_backpressure();
      logic [4:0] held;
      send(1, 10, 0, 10);
      held = act_vec();
      tests++;
      if (held !== exp_vec()) begin
         fails++;
         $display("FAIL bp_first: got %b want %b", held, exp_vec());
      end
      for (int i = 0; i < 10; i++) begin
         valid_in = i[0];
         flush    = (i % 3 == 0);
         lab_in_a = 1'($urandom);
         lab_in_v = 1'($urandom);
         dist_a   = DW'($urandom_range(0, 200));
         dist_v   = DW'($urandom_range(0, 200));
         @(negedge clk);
         tests++;
         if ({act_vec(), ready_out} !== {held, 1'b0}) begin
            fails++;
            $display("FAIL bp_hold[%0d]: got %b want %b",
                     i, {act_vec(), ready_out}, {held, 1'b0});
         end
      end
      valid_in = 0;
      flush = 0;
      release_out();
      send(0, 20, 1, 20);
      tests++;
      if (act_vec() !== exp_vec()) begin
         fails++;
         $display("FAIL bp_after: got %b want %b", act_vec(), exp_vec());
      end
      release_out();
   endtask

   task automatic test_flush();
      do_flush();
      repeat (3) begin
         send(1, 100, 1, 100);
         release_out();
      end
      @(negedge clk);
      flush = 1; valid_in = 1; lab_in_a = 0; dist_a = 10;
      lab_in_v = 0; dist_v = 10;
      #1;
      tests++;
      if (ready_out !== 1'b0) begin
         fails++;
         $display("FAIL flush_ready: got %b want 0", ready_out);
      end
      @(posedge clk);
      @(negedge clk);
      flush = 0; valid_in = 0;
      model_clear();
      repeat (3) @(negedge clk);
      tests++;
      if ({valid_out, ready_out} !== 2'b01) begin
         fails++;
         $display("FAIL flush_noaccept: got %b want 01",
                  {valid_out, ready_out});
      end
      send(0, 10, 0, 10);
      tests++;
      if (act_vec() !== 5'b10011 || act_vec() !== exp_vec()) begin
         fails++;
         $display("FAIL flush_next: got %b want 10011", act_vec());
      end
      release_out();
   endtask

   task automatic test_reset_mid();
      repeat (3) begin
         send(0, 100, 0, 100);
         release_out();
      end
      @(negedge clk);
      valid_in = 1; lab_in_a = 0; dist_a = 100; lab_in_v = 0; dist_v = 100;
      @(posedge clk);
      @(negedge clk);
      valid_in = 0;
      @(posedge clk);
      @(negedge clk);
      rst = 1;
      #1;
      tests++;
      if ({act_vec(), ready_out} !== 6'b000001) begin
         fails++;
         $display("FAIL reset_mid: got %b want 000001",
                  {act_vec(), ready_out});
      end
      model_clear();
      ref_lab = '{0, 0};
      ref_conf = '{0, 0};
      @(negedge clk);
      rst = 0;
      repeat (3) @(negedge clk);
      tests++;
      if (valid_out !== 1'b0) begin
         fails++;
         $display("FAIL reset_discard: got %b want 0", valid_out);
      end
      send(1, 100, 1, 100);
      tests++;
      if (act_vec() !== 5'b11111 || act_vec() !== exp_vec()) begin
         fails++;
         $display("FAIL reset_empty: got %b want 11111", act_vec());
      end
      release_out();
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++) begin
         int da, dv;
         if ($urandom_range(0, 7) == 0) do_flush();
         da = ($urandom_range(0, 1) == 1) ? int'($urandom_range(396, 404))
                                          : int'($urandom_range(0, 1023));
         dv = ($urandom_range(0, 1) == 1) ? int'($urandom_range(396, 404))
                                          : int'($urandom_range(0, 1023));
         send(1'($urandom), da, 1'($urandom), dv);
         tests++;
         if (act_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL random[%0d]: got %b want %b (da=%0d dv=%0d)",
                     i, act_vec(), exp_vec(), da, dv);
         end
         release_out();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_majority();
      test_threshold();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
